dbram_arbiter: RTL and testbench
================================

Name: dbram_arbiter

Overview:
Two-requester arbiter in front of the data BRAM, which has 4096 x 32-bit words, one read port, one byte-masked write port, and 1-cycle read latency. It shares the BRAM between requester 0 (core LSU) and requester 1 (debug/DMA bus). A read from one requester and a write from the other issue in the same cycle. Same-kind conflicts are resolved round-robin. Same-cycle read/write to one address is forwarded so reads see the new bytes.

Parameters:
AW, 12, word address width (BRAM depth 2^AW)
DW, 32, data width; byte lanes = DW/8

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
r_valid  in  2  per-requester request valid (bit i = requester i)
r_ready  out  2  per-requester request accepted this cycle
r_write  in  2  1 = write, 0 = read
r_addr  in  2xAW  word addresses
r_wmask  in  2x(DW/8)  byte enables, writes only
r_wdata  in  2xDW  write data
s_valid  out  2  per-requester read response valid (pulse)
s_data  out  DW  read response data (shared; qualified by s_valid)
b_rd_en  out  1  BRAM read enable
b_rd_addr  out  AW  BRAM read address
b_rd_data  in  DW  BRAM read data (registered, 1 cycle after b_rd_en)
b_wr_en  out  DW/8  BRAM byte write enables
b_wr_addr  out  AW  BRAM write address
b_wr_data  out  DW  BRAM write data

Behaviour:
- Clock clk; reset rst is synchronous and active-high.
- Reset: rd_rr = 0, wr_rr = 0, s_valid = 0, internal pending-read state cleared. r_ready is combinational and is 0 while rst is high.
- Classification: requester i is a reader if r_valid[i] & ~r_write[i], and a writer if r_valid[i] & r_write[i].
- Read grant: one reader gets it. Two readers: grant rd_rr, then rd_rr <= ~granted index.
- Write grant: same rule using wr_rr.
- A reader and a writer from different requesters are both granted in the same cycle.
- r_ready[i] = granted this cycle. Handshake is valid/ready. Requesters hold r_* stable until ready; the arbiter keeps no request state.
- Write with r_wmask = 0 is accepted (ready = 1) and drives b_wr_en = 0.
- BRAM drive (combinational): b_rd_en = read granted; b_rd_addr = granted reader's address. b_wr_en = granted writer's mask (else 0); b_wr_addr and b_wr_data from the granted writer.
- Response: 1 cycle after a read grant, s_valid[granted index] = 1 for exactly one cycle. s_data = b_rd_data merged with forwarded bytes. No response for writes. Requesters cannot backpressure responses.
- Forwarding: if a read and a write are granted in the same cycle to the same address, register the write mask and data. In the response cycle, each byte lane with mask = 1 takes the registered write byte; other lanes take b_rd_data. The result is always post-write data.
- Back-to-back reads issue every cycle; throughput is one read plus one write per cycle.
- A write granted in cycle N followed by a read of the same address in N+1 needs no forwarding; the BRAM already holds the data.
- Reset asserted while a read is in flight: s_valid is forced to 0 the next cycle and the response is dropped.
- Round-robin pointers update only on contention; an uncontended grant leaves them unchanged.

Decomposition:
- Package dbram_pkg: localparams AW, DW, NB = DW/8, plus typedef dbram_req_t {write, addr, wmask, wdata}.
- Sub-module rr_arb2: 2-way round-robin arbiter with valid[1:0] in, grant[1:0] out, and a pointer register updated on contention. It is instantiated twice, once for the read port and once for the write port.

Test Plan:
1. Reset, then both requesters idle -> r_ready = 00, s_valid = 00, b_wr_en = 0, b_rd_en = 0.
2. Req1 writes addr 0x010, data 0xDEADBEEF, mask 0xF. Next cycle req0 reads 0x010 -> one cycle later s_valid = 01, s_data = 0xDEADBEEF.
3. Both read (0x001, 0x002) and hold valid for 4 cycles -> grants alternate 0,1,0,1 (pointer at reset = 0). s_valid follows the same order one cycle later.
4. Same cycle: req0 reads 0x020 (holds 0x11223344) while req1 writes 0x020 with data 0xAABBCCDD, mask 0x5 -> both ready. Next cycle s_data = 0x11BB33DD.
5. Both write the same address in the same cycle, with masks 0x3 and 0xC -> only the rr winner is accepted. The loser is accepted next cycle. A final read returns both halves.
6. rst pulsed in the cycle after a read grant -> s_valid stays 00. rd_rr and wr_rr return to 0, so a subsequent contention grants requester 0.

Source files
------------

// File: rtl/dbram_pkg.sv
// Shared types, widths and helpers for the data-BRAM arbiter.
package dbram_pkg;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NB = DW / 8;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [NB-1:0] wmask;
      logic [DW-1:0] wdata;
   } dbram_req_t;

   // Byte-lane merge: lanes with mask set take the write byte, others the read byte.
   function automatic logic [DW-1:0] fwd_merge(input logic [DW-1:0] rd,
                                               input logic [DW-1:0] wd,
                                               input logic [NB-1:0] mask);
      logic [DW-1:0] res;
      res = rd;
      for (int b = 0; b < NB; b++) begin
         if (mask[b]) res[b*8 +: 8] = wd[b*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dbram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; pointer names the favoured requester and
// flips away from the winner only when both request.
module rr_arb2
   import dbram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid_i,
   output logic [1:0] grant_o
);

   logic ptr_q;
   logic ptr_d;

   // Grant selection and pointer next-state.
   always_comb begin
      grant_o = valid_i;
      ptr_d   = ptr_q;
      if (valid_i == 2'b11) begin
         grant_o        = 2'b00;
         grant_o[ptr_q] = 1'b1;
         ptr_d          = ~ptr_q;
      end
   end

   // Pointer register, cleared to favour requester 0.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= 1'b0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/dbram_arbiter.sv
// Shares one read port and one byte-masked write port of the data BRAM
// between the core LSU (requester 0) and the debug/DMA bus (requester 1).
module dbram_arbiter
   import dbram_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      r_valid,
   output logic [1:0]      r_ready,
   input  logic [1:0]      r_write,
   input  logic [2*AW-1:0] r_addr,
   input  logic [2*NB-1:0] r_wmask,
   input  logic [2*DW-1:0] r_wdata,
   output logic [1:0]      s_valid,
   output logic [DW-1:0]   s_data,
   output logic            b_rd_en,
   output logic [AW-1:0]   b_rd_addr,
   input  logic [DW-1:0]   b_rd_data,
   output logic [NB-1:0]   b_wr_en,
   output logic [AW-1:0]   b_wr_addr,
   output logic [DW-1:0]   b_wr_data
);

   dbram_req_t req [2];
   logic [1:0] rd_req;
   logic [1:0] wr_req;
   logic [1:0] rd_gnt;
   logic [1:0] wr_gnt;
   logic       rd_sel;
   logic       wr_sel;
   logic       fwd_hit;

   logic [1:0]    svld_q,     svld_d;
   logic [NB-1:0] fwd_mask_q, fwd_mask_d;
   logic [DW-1:0] fwd_data_q, fwd_data_d;

   // Unpack flat request buses and classify readers/writers; no grants in reset.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         req[i].write = r_write[i];
         req[i].addr  = r_addr[i*AW +: AW];
         req[i].wmask = r_wmask[i*NB +: NB];
         req[i].wdata = r_wdata[i*DW +: DW];
         rd_req[i]    = r_valid[i] & ~req[i].write & ~rst;
         wr_req[i]    = r_valid[i] &  req[i].write & ~rst;
      end
   end

   rr_arb2 u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i (rd_req),
      .grant_o (rd_gnt)
   );

   rr_arb2 u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .valid_i (wr_req),
      .grant_o (wr_gnt)
   );

   // BRAM port drive from the granted reader and writer.
   always_comb begin
      rd_sel    = rd_gnt[1];
      wr_sel    = wr_gnt[1];
      r_ready   = rd_gnt | wr_gnt;
      b_rd_en   = |rd_gnt;
      b_rd_addr = req[rd_sel].addr;
      b_wr_en   = (|wr_gnt) ? req[wr_sel].wmask : '0;
      b_wr_addr = req[wr_sel].addr;
      b_wr_data = req[wr_sel].wdata;
      fwd_hit   = b_rd_en && (|wr_gnt) && (b_rd_addr == b_wr_addr);
   end

   // Next-state for the response pulse and the forwarded write bytes.
   always_comb begin
      svld_d     = rd_gnt;
      fwd_mask_d = fwd_hit ? b_wr_en : '0;
      fwd_data_d = b_wr_data;
   end

   // Response/forwarding registers; the data word needs no reset because
   // it is only used through the mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         svld_q     <= 2'b00;
         fwd_mask_q <= '0;
      end else begin
         svld_q     <= svld_d;
         fwd_mask_q <= fwd_mask_d;
      end
      fwd_data_q <= fwd_data_d;
   end

   // A response whose cycle coincides with reset is dropped.
   assign s_valid = svld_q & {2{~rst}};
   assign s_data  = fwd_merge(b_rd_data, fwd_data_q, fwd_mask_q);

endmodule

// File: tb/tb_dbram_arbiter.sv
// Bench for dbram_arbiter: BRAM model, reference memory/arbitration model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dbram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  r_valid, r_write, r_ready, s_valid;
   logic [23:0] r_addr;
   logic [7:0]  r_wmask;
   logic [63:0] r_wdata;
   logic [31:0] s_data, b_rd_data, b_wr_data;
   logic        b_rd_en;
   logic [11:0] b_rd_addr, b_wr_addr;
   logic [3:0]  b_wr_en;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem     [4096];
   logic [31:0] ref_mem [4096];

   // Model state
   logic [1:0]  m_pend = 2'b00;
   logic [31:0] m_pdata = '0;
   logic        m_rdp = 1'b0, m_wrp = 1'b0;

   always #5 clk = ~clk;

   dbram_arbiter dut (
      .clk(clk), .rst(rst), .r_valid(r_valid), .r_ready(r_ready),
      .r_write(r_write), .r_addr(r_addr), .r_wmask(r_wmask), .r_wdata(r_wdata),
      .s_valid(s_valid), .s_data(s_data), .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr),
      .b_rd_data(b_rd_data), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr),
      .b_wr_data(b_wr_data)
   );

   // BRAM: read-first, 1-cycle latency, byte write enables.
   always @(posedge clk) begin
      if (b_rd_en) b_rd_data <= mem[b_rd_addr];
      for (int b = 0; b < 4; b++)
         if (b_wr_en[b]) mem[b_wr_addr][b*8 +: 8] <= b_wr_data[b*8 +: 8];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: decide winners from the arbitration rules, track the
   // memory contents, and compare every DUT output each cycle.
   always @(negedge clk) begin
      logic [1:0]  rdv, wrv, g_rd, g_wr, exp_sv;
      logic [3:0]  exp_wen;
      int          ri, wi;
      logic [11:0] ra, wa;
      for (int i = 0; i < 2; i++) begin
         rdv[i] = r_valid[i] & ~r_write[i] & ~rst;
         wrv[i] = r_valid[i] &  r_write[i] & ~rst;
      end
      ri = (rdv == 2'b11) ? int'(m_rdp) : (rdv[1] ? 1 : 0);
      wi = (wrv == 2'b11) ? int'(m_wrp) : (wrv[1] ? 1 : 0);
      g_rd = (rdv != 0) ? (2'b01 << ri) : 2'b00;
      g_wr = (wrv != 0) ? (2'b01 << wi) : 2'b00;
      ra = r_addr[ri*12 +: 12];
      wa = r_addr[wi*12 +: 12];
      exp_wen = (wrv != 0) ? r_wmask[wi*4 +: 4] : 4'h0;

      chk("r_ready", {30'd0, r_ready}, {30'd0, g_rd | g_wr});
      chk("b_rd_en", {31'd0, b_rd_en}, {31'd0, rdv != 0});
      if (rdv != 0) chk("b_rd_addr", {20'd0, b_rd_addr}, {20'd0, ra});
      chk("b_wr_en", {28'd0, b_wr_en}, {28'd0, exp_wen});
      if (exp_wen != 0) begin
         chk("b_wr_addr", {20'd0, b_wr_addr}, {20'd0, wa});
         chk("b_wr_data", b_wr_data, r_wdata[wi*32 +: 32]);
      end
      exp_sv = m_pend & {2{~rst}};
      chk("s_valid", {30'd0, s_valid}, {30'd0, exp_sv});
      if (exp_sv != 0) chk("s_data", s_data, m_pdata);

      // Advance model to the next cycle: write lands first, reads see it.
      for (int b = 0; b < 4; b++)
         if (exp_wen[b]) ref_mem[wa][b*8 +: 8] = r_wdata[wi*32 + b*8 +: 8];
      m_pend  = g_rd;
      m_pdata = ref_mem[ra];
      if (rst) begin
         m_rdp = 1'b0;
         m_wrp = 1'b0;
      end else begin
         if (rdv == 2'b11) m_rdp = ~m_rdp;
         if (wrv == 2'b11) m_wrp = ~m_wrp;
      end
   end

   task automatic set_req(input int i, input logic v, input logic w, input logic [11:0] a,
                          input logic [3:0] m, input logic [31:0] d);
      r_valid[i]         = v;
      r_write[i]         = w;
      r_addr[i*12 +: 12] = a;
      r_wmask[i*4 +: 4]  = m;
      r_wdata[i*32 +: 32] = d;
   endtask

   task automatic idle();
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 4096; a++) begin
         mem[a]     = 32'h0;
         ref_mem[a] = 32'h0;
      end
      mem[12'h020]     = 32'h11223344;
      ref_mem[12'h020] = 32'h11223344;
      b_rd_data = 32'h0;
      rst = 1'b1;
      idle();
      step();
      step();

      // 1: idle after reset
      rst = 1'b0;
      @(negedge clk);
      chk("t1_ready", {30'd0, r_ready}, 32'h0);
      chk("t1_svalid", {30'd0, s_valid}, 32'h0);
      chk("t1_wr_en", {28'd0, b_wr_en}, 32'h0);
      chk("t1_rd_en", {31'd0, b_rd_en}, 32'h0);

      // 2: write then read-back
      step();
      set_req(1, 1'b1, 1'b1, 12'h010, 4'hF, 32'hDEADBEEF);
      step();
      idle();
      set_req(0, 1'b1, 1'b0, 12'h010, 4'h0, 32'h0);
      step();
      idle();
      @(negedge clk);
      chk("t2_svalid", {30'd0, s_valid}, 32'h1);
      chk("t2_sdata", s_data, 32'hDEADBEEF);

      // 3: two readers contending alternate
      step();
      set_req(0, 1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 12'h002, 4'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t3_ready", {30'd0, r_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
         step();
      end
      idle();
      @(negedge clk);
      chk("t3_last_svalid", {30'd0, s_valid}, 32'h2);

      // 4: same-cycle read/write to one address forwards bytes
      step();
      set_req(0, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
      set_req(1, 1'b1, 1'b1, 12'h020, 4'h5, 32'hAABBCCDD);
      @(negedge clk);
      chk("t4_ready", {30'd0, r_ready}, 32'h3);
      step();
      idle();
      @(negedge clk);
      chk("t4_svalid", {30'd0, s_valid}, 32'h1);
      chk("t4_sdata", s_data, 32'h11BB33DD);

      // 5: two writers to one address, loser accepted next cycle
      step();
      set_req(0, 1'b1, 1'b1, 12'h030, 4'h3, 32'h11112222);
      set_req(1, 1'b1, 1'b1, 12'h030, 4'hC, 32'h33334444);
      @(negedge clk);
      chk("t5_ready_a", {30'd0, r_ready}, 32'h1);
      step();
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("t5_ready_b", {30'd0, r_ready}, 32'h2);
      step();
      idle();
      set_req(0, 1'b1, 1'b0, 12'h030, 4'h0, 32'h0);
      step();
      idle();
      @(negedge clk);
      chk("t5_sdata", s_data, 32'h33332222);

      // 6: reset drops an in-flight response and clears both pointers
      step();
      set_req(0, 1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 12'h002, 4'h0, 32'h0);
      @(negedge clk);
      chk("t6_ready_a", {30'd0, r_ready}, 32'h1);
      step();
      set_req(0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      @(negedge clk);
      chk("t6_ready_b", {30'd0, r_ready}, 32'h2);
      step();
      idle();
      rst = 1'b1;
      @(negedge clk);
      chk("t6_svalid_rst", {30'd0, s_valid}, 32'h0);
      step();
      rst = 1'b0;
      set_req(0, 1'b1, 1'b0, 12'h001, 4'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 12'h002, 4'h0, 32'h0);
      @(negedge clk);
      chk("t6_rd_ptr", {30'd0, r_ready}, 32'h1);
      step();
      set_req(0, 1'b1, 1'b1, 12'h040, 4'hF, 32'h01020304);
      set_req(1, 1'b1, 1'b1, 12'h040, 4'hF, 32'h05060708);
      @(negedge clk);
      chk("t6_wr_ptr", {30'd0, r_ready}, 32'h1);
      step();
      idle();
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
